// File: rtl/clock_timekeeper.sv
// 24-hour timekeeper with a 1 Hz prescaler, debounced mode/increment buttons and
// registered BCD digit outputs for the seven-segment display driver.
module clock_timekeeper #(
   parameter int TICK_DIV   = 100000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic       sec_tick,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;

   // bit 0 = mode button, bit 1 = increment button
   logic [1:0] btn_raw;
   logic [1:0] press;
   assign btn_raw = {btn_inc, btn_mode};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          level_reg;
         logic          press_reg;
         logic [DW-1:0] cnt_reg;

         // The press pulse fires on the same edge the debounced level rises.
         always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               press_reg <= 1'b0;
               if (sync2_reg != level_reg) begin
                  if (cnt_reg == DEB_LAST) begin
                     level_reg <= sync2_reg;
                     press_reg <= sync2_reg;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + DW'(1);
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                          input logic [3:0] t_max, input logic [3:0] o_max);
      if (t == t_max && o == o_max) return 8'h00;
      else if (o == 4'd9)           return {t + 4'd1, 4'd0};
      else                          return {t, o + 4'd1};
   endfunction

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [3:0]    sec_t_reg, sec_t_next, sec_o_reg, sec_o_next;
   logic [3:0]    min_t_reg, min_t_next, min_o_reg, min_o_next;
   logic [3:0]    hr_t_reg, hr_t_next, hr_o_reg, hr_o_next;
   logic          sec_tick_reg, sec_tick_next;
   logic          blink_reg, blink_next;
   logic          tick, sec_wrap, min_wrap;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg    <= RUN;
         presc_reg    <= '0;
         sec_t_reg    <= 4'd0;
         sec_o_reg    <= 4'd0;
         min_t_reg    <= 4'd0;
         min_o_reg    <= 4'd0;
         hr_t_reg     <= 4'd0;
         hr_o_reg     <= 4'd0;
         sec_tick_reg <= 1'b0;
         blink_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         presc_reg    <= presc_next;
         sec_t_reg    <= sec_t_next;
         sec_o_reg    <= sec_o_next;
         min_t_reg    <= min_t_next;
         min_o_reg    <= min_o_next;
         hr_t_reg     <= hr_t_next;
         hr_o_reg     <= hr_o_next;
         sec_tick_reg <= sec_tick_next;
         blink_reg    <= blink_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      sec_t_next    = sec_t_reg;
      sec_o_next    = sec_o_reg;
      min_t_next    = min_t_reg;
      min_o_next    = min_o_reg;
      hr_t_next     = hr_t_reg;
      hr_o_next     = hr_o_reg;
      sec_tick_next = 1'b0;
      tick          = (presc_reg == PRE_LAST);
      sec_wrap      = (sec_t_reg == 4'd5) && (sec_o_reg == 4'd9);
      min_wrap      = (min_t_reg == 4'd5) && (min_o_reg == 4'd9);
      presc_next    = tick ? '0 : presc_reg + PW'(1);

      // A mode press takes priority over both the tick and an increment press.
      case (state_reg)
         RUN: begin
            if (press[0]) begin
               state_next = SET_HR;
               sec_t_next = 4'd0;
               sec_o_next = 4'd0;
               presc_next = '0;
            end else if (tick) begin
               sec_tick_next = 1'b1;
               {sec_t_next, sec_o_next} = bcd_inc(sec_t_reg, sec_o_reg, 4'd5, 4'd9);
               if (sec_wrap) begin
                  {min_t_next, min_o_next} = bcd_inc(min_t_reg, min_o_reg, 4'd5, 4'd9);
                  if (min_wrap)
                     {hr_t_next, hr_o_next} = bcd_inc(hr_t_reg, hr_o_reg, 4'd2, 4'd3);
               end
            end
         end
         SET_HR: begin
            if (press[0])
               state_next = SET_MIN;
            else if (press[1])
               {hr_t_next, hr_o_next} = bcd_inc(hr_t_reg, hr_o_reg, 4'd2, 4'd3);
         end
         SET_MIN: begin
            if (press[0]) begin
               state_next = RUN;
               presc_next = '0;
            end else if (press[1]) begin
               {min_t_next, min_o_next} = bcd_inc(min_t_reg, min_o_reg, 4'd5, 4'd9);
            end
         end
         default: state_next = RUN;
      endcase

      blink_next = (state_next != RUN) && (presc_next < PRE_HALF);
   end

   assign hr_tens  = hr_t_reg;
   assign hr_ones  = hr_o_reg;
   assign min_tens = min_t_reg;
   assign min_ones = min_o_reg;
   assign sec_tick = sec_tick_reg;
   assign mode     = state_reg;
   assign blink    = blink_reg;

endmodule
